mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Two-requester command/response bundle plus the single-port memory signals
// of the shared-memory arbiter.
interface mem_arbiter_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 16
);
   logic              req0;
   logic              we0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              gnt0;
   logic              rvalid0;
   logic [DATA_W-1:0] rdata0;

   logic              req1;
   logic              we1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic              gnt1;
   logic              rvalid1;
   logic [DATA_W-1:0] rdata1;

   logic              mem_ena;
   logic [0:0]        mem_wea;
   logic [ADDR_W-1:0] mem_addra;
   logic [DATA_W-1:0] mem_dina;
   logic [DATA_W-1:0] mem_douta;

   modport slave (
      input  req0, we0, addr0, wdata0,
      output gnt0, rvalid0, rdata0,
      input  req1, we1, addr1, wdata1,
      output gnt1, rvalid1, rdata1,
      output mem_ena, mem_wea, mem_addra, mem_dina,
      input  mem_douta
   );

   modport master (
      output req0, we0, addr0, wdata0,
      input  gnt0, rvalid0, rdata0,
      output req1, we1, addr1, wdata1,
      input  gnt1, rvalid1, rdata1,
      input  mem_ena, mem_wea, mem_addra, mem_dina,
      output mem_douta
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving two requesters access to one single-port memory,
// one access every three cycles.
//
// state | meaning
// IDLE  | no access in flight; arbitrate requests, latch winner's command
// ISSUE | drive latched command to memory, pulse winner's gnt
// DATA  | memory read data valid; capture it for a read winner
module mem_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 16
) (
   input logic          clk_g,
   input logic          rst,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DATA  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              last_gnt;
   logic              winner;
   logic              pick1;
   logic              any_req;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata0_q;
   logic [DATA_W-1:0] rdata1_q;
   logic              rvalid0_q;
   logic              rvalid1_q;

   assign any_req = bus.req0 | bus.req1;

   // on a tie the port that did not win last time goes first
   always_comb begin
      if (bus.req0 && bus.req1) pick1 = ~last_gnt;
      else                      pick1 = bus.req1;
   end

   always_ff @(posedge clk_g) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = ISSUE;
         ISSUE:   state_nxt = DATA;
         DATA:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_g) begin
      if (rst) begin
         last_gnt  <= 1'b1;
         winner    <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         if (state == IDLE && any_req) begin
            winner   <= pick1;
            last_gnt <= pick1;
            we_q     <= pick1 ? bus.we1    : bus.we0;
            addr_q   <= pick1 ? bus.addr1  : bus.addr0;
            wdata_q  <= pick1 ? bus.wdata1 : bus.wdata0;
         end
         if (state == DATA && !we_q) begin
            if (winner) begin
               rdata1_q  <= bus.mem_douta;
               rvalid1_q <= 1'b1;
            end else begin
               rdata0_q  <= bus.mem_douta;
               rvalid0_q <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      bus.gnt0      = 1'b0;
      bus.gnt1      = 1'b0;
      bus.mem_ena   = 1'b0;
      bus.mem_wea   = 1'b0;
      bus.mem_addra = '0;
      bus.mem_dina  = '0;
      if (state == ISSUE) begin
         bus.gnt0      = ~winner;
         bus.gnt1      = winner;
         bus.mem_ena   = 1'b1;
         bus.mem_wea   = we_q;
         bus.mem_addra = addr_q;
         bus.mem_dina  = wdata_q;
      end
   end

   assign bus.rvalid0 = rvalid0_q;
   assign bus.rvalid1 = rvalid1_q;
   assign bus.rdata0  = rdata0_q;
   assign bus.rdata1  = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-schedule reference model checked every
// cycle, directed scenarios plus a randomized request/reset phase.
module tb_mem_arbiter;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 16;

   logic clk_g = 1'b0;
   logic rst   = 1'b1;
   always #5 clk_g = ~clk_g;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk_g (clk_g),
      .rst   (rst),
      .bus   (bus)
   );

   // single-port memory, registered read
   logic [DATA_W-1:0] mem [16] = '{default: '0};
   always @(posedge clk_g) begin
      if (bus.mem_ena) begin
         if (bus.mem_wea[0]) mem[bus.mem_addra] <= bus.mem_dina;
         bus.mem_douta <= mem[bus.mem_addra];
      end
   end

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // requesters
   bit   [1:0]        pend;
   bit   [1:0]        r_we;
   logic [ADDR_W-1:0] r_addr  [2];
   logic [DATA_W-1:0] r_wdata [2];

   // reference model: each accepted request schedules a grant cycle and,
   // for reads, a response cycle with the data the memory holds
   typedef struct { int port; bit we; int addr; int wdata; } iss_t;
   typedef struct { int port; int data; } rv_t;
   iss_t exp_iss [int];
   rv_t  exp_rv  [int];
   int   ref_mem [16];
   int   next_free = 0;
   int   last      = 1;
   int   clr_cyc   = -1;
   int   cur_rdata [2];
   int   rv_seen   [2];
   int   log_port [$];
   int   log_cyc  [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, expv);
      end
   endtask

   task automatic drive_inputs();
      bus.req0   = pend[0];
      bus.we0    = r_we[0];
      bus.addr0  = r_addr[0];
      bus.wdata0 = r_wdata[0];
      bus.req1   = pend[1];
      bus.we1    = r_we[1];
      bus.addr1  = r_addr[1];
      bus.wdata1 = r_wdata[1];
   endtask

   task automatic model_update();
      int w;
      iss_t g;
      if (rst) begin
         exp_iss.delete();
         exp_rv.delete();
         last      = 1;
         next_free = cyc + 1;
         clr_cyc   = cyc + 1;
      end else if (cyc >= next_free && (pend[0] || pend[1])) begin
         if (pend[0] && pend[1]) w = (last == 0) ? 1 : 0;
         else                    w = pend[1] ? 1 : 0;
         last    = w;
         g.port  = w;
         g.we    = r_we[w];
         g.addr  = int'(r_addr[w]);
         g.wdata = int'(r_wdata[w]);
         exp_iss[cyc + 1] = g;
         if (g.we) ref_mem[g.addr] = g.wdata;
         else      exp_rv[cyc + 3] = '{port: w, data: ref_mem[g.addr]};
         next_free = cyc + 3;
      end
   endtask

   task automatic check_cycle();
      logic        e_g0, e_g1, e_ena, e_we, e_rv0, e_rv1;
      logic [31:0] e_addr, e_din;
      e_g0 = 0; e_g1 = 0; e_ena = 0; e_we = 0; e_rv0 = 0; e_rv1 = 0;
      e_addr = 0; e_din = 0;
      if (cyc == clr_cyc) begin
         cur_rdata[0] = 0;
         cur_rdata[1] = 0;
      end
      if (exp_iss.exists(cyc)) begin
         e_ena  = 1;
         e_g0   = (exp_iss[cyc].port == 0);
         e_g1   = (exp_iss[cyc].port == 1);
         e_we   = exp_iss[cyc].we;
         e_addr = exp_iss[cyc].addr;
         e_din  = exp_iss[cyc].wdata;
         exp_iss.delete(cyc);
      end
      if (exp_rv.exists(cyc)) begin
         if (exp_rv[cyc].port == 0) e_rv0 = 1;
         else                       e_rv1 = 1;
         cur_rdata[exp_rv[cyc].port] = exp_rv[cyc].data;
         exp_rv.delete(cyc);
      end
      chk("gnt0",      bus.gnt0,       e_g0);
      chk("gnt1",      bus.gnt1,       e_g1);
      chk("mem_ena",   bus.mem_ena,    e_ena);
      chk("mem_wea",   bus.mem_wea,    e_we);
      chk("mem_addra", bus.mem_addra,  e_addr);
      chk("mem_dina",  bus.mem_dina,   e_din);
      chk("rvalid0",   bus.rvalid0,    e_rv0);
      chk("rvalid1",   bus.rvalid1,    e_rv1);
      chk("rdata0",    bus.rdata0,     cur_rdata[0]);
      chk("rdata1",    bus.rdata1,     cur_rdata[1]);
   endtask

   task automatic step();
      drive_inputs();
      model_update();
      @(posedge clk_g);
      #1;
      cyc++;
      check_cycle();
      if (bus.gnt0) begin pend[0] = 0; log_port.push_back(0); log_cyc.push_back(cyc); end
      if (bus.gnt1) begin pend[1] = 0; log_port.push_back(1); log_cyc.push_back(cyc); end
      if (bus.rvalid0) rv_seen[0]++;
      if (bus.rvalid1) rv_seen[1]++;
   endtask

   task automatic issue(input int p, input bit we, input int addr, input int wdata);
      pend[p]    = 1;
      r_we[p]    = we;
      r_addr[p]  = ADDR_W'(addr);
      r_wdata[p] = we ? DATA_W'(wdata) : '0;
   endtask

   task automatic do_reset();
      pend = 0;
      rst  = 1;
      step();
      rst  = 0;
   endtask

   task automatic drain();
      int n = 0;
      while ((pend[0] || pend[1]) && n < 30) begin
         step();
         n++;
      end
      chk("drain_timeout", {30'd0, pend}, 0);
      repeat (3) step();
   endtask

   task automatic wait_rvalid(input int p);
      int  n = 0;
      bit  seen = 0;
      while (!seen && n < 10) begin
         step();
         n++;
         seen = (p == 0) ? bus.rvalid0 : bus.rvalid1;
      end
      chk("rvalid_timeout", seen, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      pend = 0; r_we = 0;
      r_addr[0] = '0; r_addr[1] = '0; r_wdata[0] = '0; r_wdata[1] = '0;
      cur_rdata[0] = 0; cur_rdata[1] = 0;
      for (int i = 0; i < 16; i++) ref_mem[i] = 0;

      // write then read back on the other port
      do_reset();
      issue(0, 1, 3, 'hA5A5);
      drain();
      issue(1, 0, 3, 0);
      wait_rvalid(1);
      chk("rd1_a5a5",    bus.rdata1, 32'hA5A5);
      chk("rdata0_zero", bus.rdata0, 32'h0);

      // simultaneous requests held: 0, 1, 0 three cycles apart
      do_reset();
      log_port.delete();
      log_cyc.delete();
      issue(0, 0, 1, 0);
      issue(1, 0, 2, 0);
      for (int i = 0; i < 10; i++) begin
         step();
         if (!pend[0]) issue(0, 0, 1, 0);
         if (!pend[1]) issue(1, 0, 2, 0);
      end
      chk("tie_count", log_port.size() >= 3, 1);
      if (log_port.size() >= 3) begin
         chk("tie_first",  log_port[0], 0);
         chk("tie_second", log_port[1], 1);
         chk("tie_third",  log_port[2], 0);
         chk("tie_gap1",   log_cyc[1] - log_cyc[0], 3);
         chk("tie_gap2",   log_cyc[2] - log_cyc[1], 3);
      end

      // reset during DATA of a port-0 read aborts the response
      do_reset();
      issue(1, 1, 5, 'h1234);
      drain();
      issue(0, 0, 5, 0);
      begin
         int n = 0;
         while (pend[0] && n < 10) begin step(); n++; end
         chk("abort_gnt_timeout", pend[0], 0);
      end
      step();
      rv_seen[0] = 0;
      rst = 1;
      step();
      rst = 0;
      chk("abort_ena",   bus.mem_ena, 0);
      chk("abort_rdata", bus.rdata0,  0);
      repeat (4) step();
      chk("abort_rv0", rv_seen[0], 0);

      // fill all addresses, read back on port 1
      do_reset();
      for (int a = 0; a < 16; a++) begin
         issue(0, 1, a, a * 'h1111);
         drain();
      end
      for (int a = 0; a < 16; a++) begin
         issue(1, 0, a, 0);
         wait_rvalid(1);
         chk("readback", bus.rdata1, (a * 32'h1111) & 32'hFFFF);
         drain();
      end

      // random traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && $urandom_range(1, 0) == 1)
               issue(p, 1'($urandom_range(1, 0)), int'($urandom_range(15, 0)),
                     int'($urandom_range(16'hFFFF, 0)));
         end
         rst = ($urandom_range(49, 0) == 0);
         step();
      end
      rst = 0;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
